// File: rtl/idct_1d_seq_if.sv
// Handshake bundle for the 1-D IDCT block.
// Valid/ready rule on both channels: a transfer happens on a rising clk edge
// where valid && ready are both high; the producer keeps valid and data
// stable until that edge, and ready may depend on the consumer's state only.
interface idct_1d_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;

   // Producer of coefficients / consumer of samples (the bench side)
   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out
   );

   // The IDCT block itself
   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/idct_1d_seq.sv
// Sequential 8-point 1-D IDCT. One coefficient Xk is folded into all eight
// accumulators per cycle (k = 0..7); the last cycle rounds, shifts and clamps
// the sums straight into the output register, so a result appears 8 cycles
// after the accepting edge.
module idct_1d_seq #(
   parameter int SHIFT = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   idct_1d_seq_if.slave bus,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic signed [19:0] RND = 20'sd1 <<< (SHIFT - 1);

   state_t             r_state;
   logic [2:0]         r_k;
   logic [63:0]        r_coef;
   logic signed [19:0] r_acc [8];
   logic [63:0]        r_data_out;
   logic               r_in_ready;
   logic               r_out_valid;

   logic [2:0]         w_xsel;
   logic signed [7:0]  w_x;
   logic signed [8:0]  w_wt   [8];
   logic signed [16:0] w_prod [8];
   logic signed [19:0] w_sum  [8];
   logic signed [19:0] w_rnd  [8];
   logic [63:0]        w_pix;

   // Cosine magnitude c_m for m = 1..7 (c4 is also the DC weight)
   function automatic logic signed [8:0] f_cval(input int m);
      logic signed [8:0] v;
      case (m)
         1:       v = 9'sd126;
         2:       v = 9'sd118;
         3:       v = 9'sd106;
         4:       v = 9'sd91;
         5:       v = 9'sd71;
         6:       v = 9'sd49;
         7:       v = 9'sd25;
         default: v = 9'sd0;
      endcase
      return v;
   endfunction

   // Signed weight W(n,k): phase (2n+1)k folded into the first half-period
   function automatic logic signed [8:0] f_weight(input int n, input int k);
      int m;
      logic signed [8:0] v;
      if (k == 0) begin
         v = f_cval(4);
      end else begin
         m = ((2 * n + 1) * k) % 32;
         if (m > 16) m = 32 - m;
         if (m < 8)       v = f_cval(m);
         else if (m == 8) v = 9'sd0;
         else             v = -f_cval(16 - m);
      end
      return v;
   endfunction

   // Select Xk, form the eight running sums and their clamped 8-bit samples
   always_comb begin
      w_xsel = 3'd7 - r_k;
      w_x    = signed'(r_coef[{w_xsel, 3'b000} +: 8]);
      w_pix  = '0;
      for (int n = 0; n < 8; n++) begin
         w_wt[n]   = f_weight(n, int'(r_k));
         w_prod[n] = w_wt[n] * w_x;
         w_sum[n]  = r_acc[n] + {{3{w_prod[n][16]}}, w_prod[n]};
         w_rnd[n]  = (w_sum[n] + RND) >>> SHIFT;
         if (w_rnd[n] < 0)
            w_pix[8*(7-n) +: 8] = 8'd0;
         else if (w_rnd[n] > 20'sd255)
            w_pix[8*(7-n) +: 8] = 8'd255;
         else
            w_pix[8*(7-n) +: 8] = w_rnd[n][7:0];
      end
   end

   // Control FSM with registered handshake outputs and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_k         <= 3'd0;
         r_coef      <= '0;
         r_data_out  <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         for (int n = 0; n < 8; n++) r_acc[n] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_coef     <= bus.data_in;
                  r_k        <= 3'd0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_COMPUTE;
                  for (int n = 0; n < 8; n++) r_acc[n] <= '0;
               end
            end
            S_COMPUTE: begin
               for (int n = 0; n < 8; n++) r_acc[n] <= w_sum[n];
               r_k <= r_k + 3'd1;
               if (r_k == 3'd7) begin
                  r_data_out  <= w_pix;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data_out;
   assign o_state       = r_state;

endmodule

// File: tb/tb_idct_1d_seq.sv
// Bench for idct_1d_seq: directed vectors, a direct-formula IDCT model
// feeding an expected queue, and one negedge compare process.
module tb_idct_1d_seq;

   localparam int SHIFT = 5;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   idct_1d_seq_if bus ();

   idct_1d_seq #(.SHIFT(SHIFT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .o_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   logic [63:0] exp_q [$];
   logic [63:0] last_out;

   // ---------------- model ----------------
   // Direct evaluation of x_n = clamp(round(sum_k W(n,k) * Xk) >> SHIFT)
   function automatic logic [63:0] model(input logic [63:0] d);
      int c [8];
      int acc, r, m, wgt, x;
      logic [63:0] res;
      c = '{0, 126, 118, 106, 91, 71, 49, 25};
      res = '0;
      for (int n = 0; n < 8; n++) begin
         acc = 0;
         for (int k = 0; k < 8; k++) begin
            x = int'(signed'(d[8*(7-k) +: 8]));
            if (k == 0) wgt = c[4];
            else begin
               m = ((2*n+1)*k) % 32;
               if (m > 16) m = 32 - m;
               if (m < 8)       wgt = c[m];
               else if (m == 8) wgt = 0;
               else             wgt = -c[16-m];
            end
            acc = acc + wgt * x;
         end
         r = (acc + (1 << (SHIFT-1))) >>> SHIFT;
         if (r < 0) r = 0;
         if (r > 255) r = 255;
         res[8*(7-n) +: 8] = r[7:0];
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_valid_exclusive", {63'd0, bus.in_ready & bus.out_valid}, 64'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected none", bus.data_out);
            end else begin
               chk("data_out", bus.data_out, exp_q[0]);
               last_out = exp_q.pop_front();
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present d at a negedge while idle; returns after the accepting edge.
   task automatic accept_vec(input logic [63:0] d, input int hold);
      int waitc;
      waitc = 0;
      @(negedge clk);
      while (!bus.in_ready && waitc < 30) begin
         @(negedge clk);
         waitc++;
      end
      chk("idle_timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.out_ready = (hold == 0);
      bus.data_in   = d;
      bus.in_valid  = 1'b1;
      exp_q.push_back(model(d));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.data_in  = {$urandom, $urandom};
      chk("in_ready_after_accept", {63'd0, bus.in_ready}, 64'd0);
   endtask

   // Wait for out_valid, check latency/holding, stall for hold cycles, drain.
   task automatic finish_vec(input int hold, input logic [63:0] expv);
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (!bus.out_valid) chk("data_out_kept", bus.data_out, last_out);
      end
      chk("latency", 64'(lat), 64'd8);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = {$urandom, $urandom};
         @(posedge clk);
         #1;
         chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("stall_data_out", bus.data_out, expv);
         chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
   endtask

   task automatic run_vec(input logic [63:0] d, input int hold);
      accept_vec(d, hold);
      finish_vec(hold, model(d));
   endtask

   // ---------------- main sequence ----------------
   logic [63:0] m31;

   initial begin
      n_vec         = 0;
      n_err         = 0;
      last_out      = '0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b1;

      // hand-computed values pinning the model
      chk("model_zero", model(64'h0), 64'h0);
      chk("model_dc40", model(64'h4000_0000_0000_0000), 64'hB6B6_B6B6_B6B6_B6B6);
      chk("model_dc7f", model(64'h7F00_0000_0000_0000), 64'hFFFF_FFFF_FFFF_FFFF);
      m31 = model(64'h00C0_0000_0000_0000);
      chk("model_x1_x0", {56'd0, m31[63:56]}, 64'h00);
      chk("model_x1_x7", {56'd0, m31[7:0]}, 64'hFC);

      #12;
      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_data_out", bus.data_out, 64'd0);
      chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec(64'h0000_0000_0000_0000, 0);
      run_vec(64'h4000_0000_0000_0000, 0);
      run_vec(64'h7F00_0000_0000_0000, 0);
      run_vec(64'h00C0_0000_0000_0000, 0);
      run_vec(64'h10F0_0800_FC02_0001, 0);
      run_vec(64'h8080_8080_8080_8080, 5);
      run_vec(64'h7F7F_7F7F_7F7F_7F7F, 0);
      run_vec(64'h2AD6_1133_E5C7_0A9C, 2);

      // reset in the middle of COMPUTE (k = 4)
      accept_vec(64'h7F00_0000_0000_0000, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("midreset_data_out", bus.data_out, 64'd0);
      chk("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      exp_q.delete();
      last_out = '0;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      bus.data_in   = 64'h4000_0000_0000_0000;
      bus.in_valid  = 1'b1;
      exp_q.push_back(64'hB6B6_B6B6_B6B6_B6B6);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("first_edge_accept", {63'd0, bus.in_ready}, 64'd0);
      finish_vec(0, 64'hB6B6_B6B6_B6B6_B6B6);

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
